cpu_hazard_scoreboard: RTL and testbench
========================================

CPU_HAZARD_SCOREBOARD -- requirements
Module: cpu_hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter TAG_W, default 4, meaning pipeline tag width.
REQ-002 The block SHALL have parameter MAX_INFLIGHT, default 4 (range 1..7), meaning the maximum number of outstanding register writes.
REQ-003 Port i_clock  in  1  single clock; all state updates on the rising edge.
REQ-004 Port i_reset  in  1  reset, synchronous and active-high.
REQ-005 Port i_issue_tag  in  TAG_W  tag of the instruction presented by decode; a change versus the last accepted tag marks a new instruction.
REQ-006 Port i_issue_rs1 / i_issue_rs2 / i_issue_rd  in  5 each  register indices from decode; 0 means none.
REQ-007 Port i_issue_fence  in  1  the presented instruction requires an empty pipeline before issue.
REQ-008 Port i_wb_tag  in  TAG_W  writeback tag; a change versus the last seen writeback tag marks one retirement.
REQ-009 Port i_wb_rd  in  5  register retired by that writeback.
REQ-010 Port i_flush  in  1  discard all outstanding writes (branch redirect).
REQ-011 Port o_stall  out  1  decode must hold; the presented instruction is not issued.
REQ-012 Port o_inflight  out  3  number of outstanding writes.
REQ-013 Port o_error  out  1  sticky; a retirement occurred with no matching outstanding write.

Function
REQ-014 The block SHALL keep one 2-bit pending counter per register 1..31 (register 0 has none) plus a total count; o_inflight SHALL equal that total.
REQ-015 A pending presentation SHALL exist when i_issue_tag differs from the registered last-issue tag.
REQ-016 o_stall SHALL be combinational from the inputs and the registered state, and SHALL be 1 when any of the following holds while a presentation is pending:
- rs1 != 0 and pending[rs1] != 0
- rs2 != 0 and pending[rs2] != 0
- rd != 0 and pending[rd] == 3
- rd != 0 and total == MAX_INFLIGHT
- state is DRAIN
REQ-017 o_stall SHALL be 0 when no presentation is pending.
REQ-018 Issue SHALL occur on a clock edge where a presentation is pending, o_stall is 0, and i_flush is 0. On issue:
- the last-issue tag SHALL load i_issue_tag;
- if rd != 0, pending[rd] and total SHALL each increment by 1.
REQ-019 Retire SHALL occur on a clock edge where i_wb_tag differs from the registered last-wb tag. On retire:
- the last-wb tag SHALL load i_wb_tag;
- if wb_rd != 0 and pending[wb_rd] != 0, pending[wb_rd] and total SHALL each decrement by 1;
- if wb_rd != 0 and pending[wb_rd] == 0, no counter SHALL change and o_error SHALL set.
REQ-020 Issue and retire on the same edge to the same rd SHALL leave pending[rd] and total unchanged.
REQ-021 Issue and retire on the same edge to different registers SHALL each apply independently.
REQ-022 A retirement SHALL NOT bypass into o_stall: a dependent instruction SHALL still see o_stall=1 in the retire cycle and o_stall=0 from the next cycle.
REQ-023 State machine, RUN to DRAIN: on a pending presentation with i_issue_fence=1, total != 0, and state RUN, the state SHALL move to DRAIN and the instruction SHALL NOT issue.
REQ-024 State machine, DRAIN to RUN: in DRAIN, when total == 0 the state SHALL return to RUN on the next edge, and the fence SHALL issue in the cycle after that, subject to REQ-016.
REQ-025 State machine, fence on empty pipeline: a fence presented in RUN with total == 0 SHALL issue without entering DRAIN.
REQ-026 Flush, counters: i_flush=1 SHALL clear all pending counters and total, and SHALL force state RUN on the next edge.
REQ-027 Flush, same-edge events: on a flush edge, a same-edge issue SHALL be suppressed and a same-edge retirement SHALL only update the last-wb tag.
REQ-028 Flush, tags: flush SHALL NOT alter the last-issue tag.
REQ-029 Counter bounds: counters SHALL never wrap; REQ-016 prevents overflow and REQ-019 prevents underflow.

Reset
REQ-030 While i_reset=1 on an edge, the block SHALL clear all pending counters, total, and o_error, zero both last-tag registers, and enter state RUN; reset SHALL take priority over flush, issue, and retire.
REQ-031 After reset with i_issue_tag=0 and i_wb_tag=0, the block SHALL present o_stall=0, o_inflight=0, and o_error=0.
REQ-032 Reset asserted in DRAIN or with writes outstanding SHALL return the block to the REQ-030 state on that edge.

Verification
REQ-033 Issue tag1 with rd=5, then tag2 with rs1=5 -> o_stall=1, o_inflight=1; wb tag1 with rd=5 -> o_stall=1 in that cycle and 0 the next, and tag2 issues.
REQ-034 Issue four distinct rd writes (x1..x4) with no retirement, then present a 5th write to x6 -> o_stall=1, o_inflight=4; one retirement -> the 5th instruction issues the following cycle.
REQ-035 Issue rd=7 while a retirement of rd=7 (count 1) occurs on the same edge -> pending[7] stays 1 and o_inflight is unchanged.
REQ-036 Two writes outstanding, present a fence -> DRAIN with o_stall=1; two retirements -> RUN, and the fence issues with o_inflight=0.
REQ-037 Three writes outstanding, pulse i_flush -> o_inflight=0 next cycle; then a retirement of rd=3 -> o_error=1 and it stays 1 until reset.
REQ-038 Reset asserted in DRAIN with o_inflight=2 -> o_inflight=0, o_stall=0, and state RUN after one edge.

Source files
------------

// File: rtl/cpu_hazard_scoreboard.sv
// Register hazard scoreboard: per-register pending-write counters gate issue
// from decode, with fence draining and flush/retire bookkeeping.
module cpu_hazard_scoreboard #(
    parameter int TAG_W        = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [TAG_W-1:0] i_issue_tag,
    input  logic [4:0]       i_issue_rs1,
    input  logic [4:0]       i_issue_rs2,
    input  logic [4:0]       i_issue_rd,
    input  logic             i_issue_fence,
    input  logic [TAG_W-1:0] i_wb_tag,
    input  logic [4:0]       i_wb_rd,
    input  logic             i_flush,
    output logic             o_stall,
    output logic [2:0]       o_inflight,
    output logic             o_error
);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t           state, state_next;
    logic [1:0]       pending [32];
    logic [2:0]       total;
    logic [TAG_W-1:0] last_issue_tag;
    logic [TAG_W-1:0] last_wb_tag;
    logic             error_q;

    logic        issue_pend, wb_new;
    logic        rs1_busy, rs2_busy, rd_saturated, full, fence_wait;
    logic        issue_go, issue_inc, retire_hit, retire_miss;
    logic [31:0] inc_vec, dec_vec;

    // Hazards are judged on registered counters only, so a retirement never
    // unblocks a dependent instruction in the same cycle.
    always_comb begin
        issue_pend   = (i_issue_tag != last_issue_tag);
        wb_new       = (i_wb_tag != last_wb_tag);
        rs1_busy     = (i_issue_rs1 != 5'd0) && (pending[i_issue_rs1] != 2'd0);
        rs2_busy     = (i_issue_rs2 != 5'd0) && (pending[i_issue_rs2] != 2'd0);
        rd_saturated = (i_issue_rd != 5'd0) && (pending[i_issue_rd] == 2'd3);
        full         = (i_issue_rd != 5'd0) && (total == 3'(MAX_INFLIGHT));
        fence_wait   = i_issue_fence && (total != 3'd0);
        o_stall      = issue_pend && (rs1_busy || rs2_busy || rd_saturated || full ||
                                      fence_wait || (state == DRAIN));
        issue_go     = issue_pend && !o_stall && !i_flush;
        issue_inc    = issue_go && (i_issue_rd != 5'd0);
        retire_hit   = wb_new && !i_flush && (i_wb_rd != 5'd0) && (pending[i_wb_rd] != 2'd0);
        retire_miss  = wb_new && !i_flush && (i_wb_rd != 5'd0) && (pending[i_wb_rd] == 2'd0);
        inc_vec      = issue_inc  ? (32'd1 << i_issue_rd) : '0;
        dec_vec      = retire_hit ? (32'd1 << i_wb_rd)    : '0;
    end

    always_comb begin
        state_next = state;
        if (i_flush) begin
            state_next = RUN;
        end else begin
            unique case (state)
                RUN:   if (issue_pend && i_issue_fence && (total != 3'd0)) state_next = DRAIN;
                DRAIN: if (total == 3'd0) state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= RUN;
        else         state <= state_next;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int unsigned r = 0; r < 32; r++) pending[r] <= '0;
            total          <= '0;
            last_issue_tag <= '0;
            last_wb_tag    <= '0;
            error_q        <= 1'b0;
        end else begin
            if (issue_go) last_issue_tag <= i_issue_tag;
            if (wb_new)   last_wb_tag    <= i_wb_tag;
            if (i_flush) begin
                for (int unsigned r = 0; r < 32; r++) pending[r] <= '0;
                total <= '0;
            end else begin
                // Issue and retire to the same register cancel each other.
                for (int unsigned r = 0; r < 32; r++) begin
                    if (inc_vec[r] && !dec_vec[r])      pending[r] <= pending[r] + 2'd1;
                    else if (dec_vec[r] && !inc_vec[r]) pending[r] <= pending[r] - 2'd1;
                end
                total <= total + {2'b00, issue_inc} - {2'b00, retire_hit};
                if (retire_miss) error_q <= 1'b1;
            end
        end
    end

    assign o_inflight = total;
    assign o_error    = error_q;

endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// Bench for cpu_hazard_scoreboard: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_cpu_hazard_scoreboard;

    localparam int TAG_W = 4;
    localparam int MAXI  = 4;

    logic             i_clock, i_reset;
    logic [TAG_W-1:0] i_issue_tag, i_wb_tag;
    logic [4:0]       i_issue_rs1, i_issue_rs2, i_issue_rd, i_wb_rd;
    logic             i_issue_fence, i_flush;
    logic             o_stall, o_error;
    logic [2:0]       o_inflight;

    cpu_hazard_scoreboard #(.TAG_W(TAG_W), .MAX_INFLIGHT(MAXI)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_issue_tag(i_issue_tag), .i_issue_rs1(i_issue_rs1), .i_issue_rs2(i_issue_rs2),
        .i_issue_rd(i_issue_rd), .i_issue_fence(i_issue_fence),
        .i_wb_tag(i_wb_tag), .i_wb_rd(i_wb_rd), .i_flush(i_flush),
        .o_stall(o_stall), .o_inflight(o_inflight), .o_error(o_error)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    // Behavioural model: outstanding writes per register, pipeline drain flag.
    int               m_cnt [32];
    int               m_total;
    bit               m_drain, m_err;
    logic [TAG_W-1:0] m_li, m_lw;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        if (i_issue_tag == m_li) return 0;
        if (i_issue_rs1 != 0 && m_cnt[i_issue_rs1] > 0) return 1;
        if (i_issue_rs2 != 0 && m_cnt[i_issue_rs2] > 0) return 1;
        if (i_issue_rd != 0 && (m_cnt[i_issue_rd] == 3 || m_total == MAXI)) return 1;
        if (m_drain) return 1;
        if (i_issue_fence && m_total != 0) return 1;
        return 0;
    endfunction

    always @(posedge i_clock) begin
        bit pend, stall, issue, new_wb;
        int pre;
        if (i_reset) begin
            foreach (m_cnt[r]) m_cnt[r] = 0;
            m_total = 0; m_drain = 0; m_err = 0; m_li = '0; m_lw = '0;
        end else begin
            pend   = (i_issue_tag != m_li);
            stall  = model_stall();
            issue  = pend && !stall && !i_flush;
            new_wb = (i_wb_tag != m_lw);
            pre    = m_cnt[i_wb_rd];
            if (new_wb) m_lw = i_wb_tag;
            if (issue)  m_li = i_issue_tag;
            if (i_flush) begin
                foreach (m_cnt[r]) m_cnt[r] = 0;
                m_total = 0; m_drain = 0;
            end else begin
                if (m_drain && m_total == 0) m_drain = 0;
                else if (!m_drain && pend && i_issue_fence && m_total != 0) m_drain = 1;
                if (issue && i_issue_rd != 0) begin
                    m_cnt[i_issue_rd]++; m_total++;
                end
                if (new_wb && i_wb_rd != 0) begin
                    if (pre > 0) begin m_cnt[i_wb_rd]--; m_total--; end
                    else m_err = 1;
                end
            end
        end
    end

    always @(negedge i_clock) begin
        if (check_en && !i_reset) begin
            check("model_stall",    32'(o_stall),    32'(model_stall()));
            check("model_inflight", 32'(o_inflight), 32'(m_total));
            check("model_error",    32'(o_error),    32'(m_err));
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic present(input int tag, input int rs1, input int rs2, input int rd, input bit fence);
        i_issue_tag = TAG_W'(tag); i_issue_rs1 = 5'(rs1); i_issue_rs2 = 5'(rs2);
        i_issue_rd = 5'(rd); i_issue_fence = fence;
    endtask

    task automatic wb(input int tag, input int rd);
        i_wb_tag = TAG_W'(tag); i_wb_rd = 5'(rd);
    endtask

    task automatic do_reset();
        i_reset = 1; present(0, 0, 0, 0, 0); wb(0, 0); i_flush = 0;
        tick();
        i_reset = 0;
        check_en = 1;
    endtask

    task automatic sample();
        #2;
    endtask

    task automatic random_cycle();
        int q[$];
        i_reset = ($urandom_range(0, 199) == 0);
        i_flush = ($urandom_range(0, 39) == 0);
        if (i_issue_tag == m_li && $urandom_range(0, 1) == 1) begin
            i_issue_tag   = m_li + TAG_W'($urandom_range(1, (1 << TAG_W) - 1));
            i_issue_rs1   = 5'($urandom_range(0, 7));
            i_issue_rs2   = 5'($urandom_range(0, 7));
            i_issue_rd    = 5'($urandom_range(0, 7));
            i_issue_fence = ($urandom_range(0, 7) == 0);
        end
        if ($urandom_range(0, 9) < 4) begin
            i_wb_tag = m_lw + TAG_W'($urandom_range(1, (1 << TAG_W) - 1));
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) q.push_back(r);
            if (q.size() > 0 && $urandom_range(0, 9) != 0)
                i_wb_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                i_wb_rd = 5'($urandom_range(0, 7));
        end
    endtask

    initial begin
        do_reset();
        sample();
        check("rst_stall", 32'(o_stall), 0);
        check("rst_inflight", 32'(o_inflight), 0);
        check("rst_error", 32'(o_error), 0);

        // RAW hazard released the cycle after its writeback.
        present(1, 0, 0, 5, 0); tick();
        present(2, 5, 0, 6, 0); sample();
        check("raw_stall", 32'(o_stall), 1);
        check("raw_inflight", 32'(o_inflight), 1);
        check("raw_model_total", 32'(m_total), 1);
        tick(); wb(1, 5); sample();
        check("raw_retire_cycle_stall", 32'(o_stall), 1);
        tick(); sample();
        check("raw_next_stall", 32'(o_stall), 0);
        check("raw_next_inflight", 32'(o_inflight), 0);
        tick(); sample();
        check("raw_issued_inflight", 32'(o_inflight), 1);

        // Capacity limit of MAX_INFLIGHT outstanding writes.
        do_reset();
        for (int k = 1; k <= 4; k++) begin present(k, 0, 0, k, 0); tick(); end
        present(5, 0, 0, 6, 0); sample();
        check("full_stall", 32'(o_stall), 1);
        check("full_inflight", 32'(o_inflight), 4);
        tick(); wb(1, 1); sample();
        check("full_retire_stall", 32'(o_stall), 1);
        tick(); sample();
        check("full_after_stall", 32'(o_stall), 0);
        check("full_after_inflight", 32'(o_inflight), 3);
        tick(); sample();
        check("full_issued_inflight", 32'(o_inflight), 4);

        // Same-edge issue and retire of the same register.
        do_reset();
        present(1, 0, 0, 7, 0); tick();
        present(2, 0, 0, 7, 0); wb(1, 7); tick();
        present(3, 7, 0, 0, 0); sample();
        check("same_inflight", 32'(o_inflight), 1);
        check("same_pending7_stall", 32'(o_stall), 1);
        check("same_model_cnt7", 32'(m_cnt[7]), 1);

        // Fence drains outstanding writes before issuing.
        do_reset();
        present(1, 0, 0, 1, 0); tick();
        present(2, 0, 0, 2, 0); tick();
        present(3, 0, 0, 0, 1); sample();
        check("fence_stall", 32'(o_stall), 1);
        tick(); wb(1, 1); sample();
        check("drain_stall", 32'(o_stall), 1);
        check("drain_model", 32'(m_drain), 1);
        tick(); wb(2, 2); tick(); sample();
        check("drain_empty_stall", 32'(o_stall), 1);
        check("drain_empty_inflight", 32'(o_inflight), 0);
        tick(); sample();
        check("run_fence_stall", 32'(o_stall), 0);
        tick(); sample();
        check("fence_issued_inflight", 32'(o_inflight), 0);
        check("fence_issued_stall", 32'(o_stall), 0);

        // Flush, then an orphan retirement sets the sticky error.
        do_reset();
        for (int k = 1; k <= 3; k++) begin present(k, 0, 0, k, 0); tick(); end
        i_flush = 1; tick(); i_flush = 0; sample();
        check("flush_inflight", 32'(o_inflight), 0);
        wb(1, 3); tick(); sample();
        check("orphan_error", 32'(o_error), 1);
        repeat (3) tick();
        sample();
        check("error_sticky", 32'(o_error), 1);

        // Reset while draining.
        do_reset();
        present(1, 0, 0, 1, 0); tick();
        present(2, 0, 0, 2, 0); tick();
        present(3, 0, 0, 0, 1); tick(); sample();
        check("pre_reset_inflight", 32'(o_inflight), 2);
        i_reset = 1; tick(); i_reset = 0; sample();
        check("reset_drain_inflight", 32'(o_inflight), 0);
        check("reset_drain_stall", 32'(o_stall), 0);

        do_reset();
        for (int c = 0; c < 4000; c++) begin
            random_cycle();
            tick();
        end
        i_reset = 0; i_flush = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
